// File: rtl/pu_da_pkg.sv
// Shared encodings for the DA (data access) stage: load/store ops, exception codes,
// DA FSM states and the DA/WB pipeline-register layout.
package pu_da_pkg;

  localparam int WORD_ADDR_W = 30;

  typedef enum logic [1:0] {
    PU_COP_OP_NO   = 2'd0,
    PU_COP_OP_MFC0 = 2'd1,
    PU_COP_OP_MTC0 = 2'd2,
    PU_COP_OP_ERET = 2'd3
  } pu_cop_op_e;

  typedef enum logic [3:0] {
    PU_LS_OP_NO  = 4'd0,
    PU_LS_OP_LB  = 4'd1,
    PU_LS_OP_LBU = 4'd2,
    PU_LS_OP_LH  = 4'd3,
    PU_LS_OP_LHU = 4'd4,
    PU_LS_OP_LW  = 4'd5,
    PU_LS_OP_SB  = 4'd6,
    PU_LS_OP_SH  = 4'd7,
    PU_LS_OP_SW  = 4'd8
  } pu_ls_op_e;

  typedef enum logic [2:0] {
    PU_EXP_EX_NO      = 3'd0,
    PU_EXP_EX_ADEF    = 3'd1,
    PU_EXP_EX_RI      = 3'd2,
    PU_EXP_EX_OVF     = 3'd3,
    PU_EXP_EX_SYSCALL = 3'd4,
    PU_EXP_EX_BREAK   = 3'd5
  } pu_exp_ex_e;

  // EX codes keep their values in DA so they can be passed through by a cast.
  typedef enum logic [2:0] {
    PU_EXP_DA_NO      = 3'd0,
    PU_EXP_DA_ADEF    = 3'd1,
    PU_EXP_DA_RI      = 3'd2,
    PU_EXP_DA_OVF     = 3'd3,
    PU_EXP_DA_SYSCALL = 3'd4,
    PU_EXP_DA_BREAK   = 3'd5,
    PU_EXP_DA_ADEL    = 3'd6,
    PU_EXP_DA_ADES    = 3'd7
  } pu_exp_da_e;

  localparam logic [1:0] DA_IDLE  = 2'd0;
  localparam logic [1:0] DA_WAIT  = 2'd1;
  localparam logic [1:0] DA_DRAIN = 2'd2;

  typedef struct packed {
    logic                   en;
    logic [WORD_ADDR_W-1:0] pc;
    pu_cop_op_e             cop_op;
    logic [4:0]             rd_addr;
    logic                   rd_en;
    logic [31:0]            rd_data;
    logic                   hi_en;
    logic [31:0]            hi_data;
    logic                   lo_en;
    logic [31:0]            lo_data;
    logic                   bd;
    pu_exp_da_e             exp;
    logic [31:0]            badvaddr;
  } da_pr_t;

endpackage

// File: rtl/pu_da_align.sv
// Combinational byte-lane logic: alignment check, byte enables, store replication
// and load extraction (little-endian, offset 0 = bits [7:0]).
module pu_da_align
  import pu_da_pkg::*;
(
  input  pu_ls_op_e   i_ls_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_st_data,
  input  logic [31:0] i_rdata,
  output logic        o_is_load,
  output logic        o_is_store,
  output logic        o_misalign,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = '0;
    case (i_addr[1:0])
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
  end

  assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_is_load  = 1'b0;
    o_is_store = 1'b0;
    o_misalign = 1'b0;
    o_be       = 4'b0000;
    o_wdata    = i_st_data;
    o_ld_data  = i_rdata;
    case (i_ls_op)
      PU_LS_OP_LB: begin
        o_is_load = 1'b1; o_be = 4'b1111;
        o_ld_data = {{24{w_byte[7]}}, w_byte};
      end
      PU_LS_OP_LBU: begin
        o_is_load = 1'b1; o_be = 4'b1111;
        o_ld_data = {24'h0, w_byte};
      end
      PU_LS_OP_LH: begin
        o_is_load = 1'b1; o_be = 4'b1111; o_misalign = i_addr[0];
        o_ld_data = {{16{w_half[15]}}, w_half};
      end
      PU_LS_OP_LHU: begin
        o_is_load = 1'b1; o_be = 4'b1111; o_misalign = i_addr[0];
        o_ld_data = {16'h0, w_half};
      end
      PU_LS_OP_LW: begin
        o_is_load = 1'b1; o_be = 4'b1111; o_misalign = |i_addr[1:0];
      end
      PU_LS_OP_SB: begin
        o_is_store = 1'b1;
        o_be       = 4'b0001 << i_addr[1:0];
        o_wdata    = {4{i_st_data[7:0]}};
      end
      PU_LS_OP_SH: begin
        o_is_store = 1'b1; o_misalign = i_addr[0];
        o_be       = i_addr[1] ? 4'b1100 : 4'b0011;
        o_wdata    = {2{i_st_data[15:0]}};
      end
      PU_LS_OP_SW: begin
        o_is_store = 1'b1; o_be = 4'b1111; o_misalign = |i_addr[1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pu_da.sv
// DA stage: drives the data bus for loads/stores, tracks outstanding accesses with an
// IDLE/WAIT/DRAIN FSM and loads the DA/WB pipeline register.
module pu_da
  import pu_da_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_,
  input  logic                   da_flush,
  input  logic                   da_stall,
  output logic                   da_busy,
  input  logic                   ex_pr_en,
  input  logic [WORD_ADDR_W-1:0] ex_pr_pc,
  input  pu_cop_op_e             ex_pr_cop_op,
  input  pu_ls_op_e              ex_pr_ls_op,
  input  logic [31:0]            ex_pr_out,
  input  logic [31:0]            ex_pr_st_data,
  input  logic [4:0]             ex_pr_rd_addr,
  input  logic                   ex_pr_rd_en,
  input  logic                   ex_pr_hi_en,
  input  logic                   ex_pr_lo_en,
  input  logic [31:0]            ex_pr_hi_data,
  input  logic [31:0]            ex_pr_lo_data,
  input  logic                   ex_pr_bd,
  input  pu_exp_ex_e             ex_pr_exp,
  output logic                   dbus_req,
  output logic                   dbus_we,
  output logic [WORD_ADDR_W-1:0] dbus_addr,
  output logic [3:0]             dbus_be,
  output logic [31:0]            dbus_wdata,
  input  logic                   dbus_ack,
  input  logic [31:0]            dbus_rdata,
  output logic                   da_pr_en,
  output logic [WORD_ADDR_W-1:0] da_pr_pc,
  output pu_cop_op_e             da_pr_cop_op,
  output logic [4:0]             da_pr_rd_addr,
  output logic                   da_pr_rd_en,
  output logic [31:0]            da_pr_rd_data,
  output logic                   da_pr_hi_en,
  output logic [31:0]            da_pr_hi_data,
  output logic                   da_pr_lo_en,
  output logic [31:0]            da_pr_lo_data,
  output logic                   da_pr_bd,
  output pu_exp_da_e             da_pr_exp,
  output logic [31:0]            da_pr_badvaddr,
  output logic [4:0]             fwd_da_rd_addr,
  output logic                   fwd_da_rd_en,
  output logic [31:0]            fwd_da_rd_data
);

  logic [1:0]  r_state, w_state_nxt;
  pu_ls_op_e   r_op;
  logic [31:0] r_baddr, r_sdata;
  logic        r_done;
  logic [31:0] r_buf;
  da_pr_t      r_pr, w_nxt;

  logic        w_idle, w_mem_op, w_req, w_adv, w_cmpl, w_dexp;
  pu_ls_op_e   w_op;
  logic [31:0] w_baddr, w_sdata, w_wdata, w_ld_data, w_ld_res;
  logic        w_ld, w_st, w_mis;
  logic [3:0]  w_be;

  assign w_idle = (r_state == DA_IDLE);

  // Outside IDLE the bus is driven from the captured request so it stays stable.
  assign w_op    = w_idle ? ex_pr_ls_op   : r_op;
  assign w_baddr = w_idle ? ex_pr_out     : r_baddr;
  assign w_sdata = w_idle ? ex_pr_st_data : r_sdata;

  pu_da_align u_align (
    .i_ls_op   (w_op),
    .i_addr    (w_baddr),
    .i_st_data (w_sdata),
    .i_rdata   (dbus_rdata),
    .o_is_load (w_ld),
    .o_is_store(w_st),
    .o_misalign(w_mis),
    .o_be      (w_be),
    .o_wdata   (w_wdata),
    .o_ld_data (w_ld_data)
  );

  assign w_mem_op = ex_pr_en && (ex_pr_ls_op != PU_LS_OP_NO) &&
                    (ex_pr_exp == PU_EXP_EX_NO) && !da_flush;
  assign w_dexp   = w_idle && w_mem_op && w_mis;

  // r_done: this EX op already finished on the bus while stalled; never reissue it.
  assign w_req = rst_ && (w_idle ? (w_mem_op && !w_mis && !r_done) : 1'b1);

  assign dbus_req   = w_req;
  assign dbus_we    = w_req && w_st;
  assign dbus_be    = w_req ? w_be : 4'b0000;
  assign dbus_addr  = w_baddr[31:2];
  assign dbus_wdata = w_wdata;

  assign da_busy  = w_req && !dbus_ack;
  assign w_adv    = !da_stall && !da_busy;
  assign w_cmpl   = w_req && dbus_ack && (r_state != DA_DRAIN) && !da_flush;
  assign w_ld_res = r_done ? r_buf : w_ld_data;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DA_IDLE:  if (w_req && !dbus_ack) w_state_nxt = DA_WAIT;
      DA_WAIT:  if (dbus_ack) w_state_nxt = DA_IDLE;
                else if (da_flush) w_state_nxt = DA_DRAIN;
      DA_DRAIN: if (dbus_ack) w_state_nxt = DA_IDLE;
      default:  w_state_nxt = DA_IDLE;
    endcase
  end

  // A flush also clears EX, so the cycle a drain finishes only ever carries a bubble.
  always_comb begin
    w_nxt = '0;
    if (da_flush || !ex_pr_en || (r_state == DA_DRAIN)) begin
      w_nxt = '0;
    end else if ((ex_pr_exp != PU_EXP_EX_NO) || w_dexp) begin
      w_nxt.en       = 1'b1;
      w_nxt.pc       = ex_pr_pc;
      w_nxt.bd       = ex_pr_bd;
      w_nxt.rd_addr  = ex_pr_rd_addr;
      w_nxt.rd_data  = ex_pr_out;
      w_nxt.hi_data  = ex_pr_hi_data;
      w_nxt.lo_data  = ex_pr_lo_data;
      w_nxt.exp      = w_dexp ? (w_ld ? PU_EXP_DA_ADEL : PU_EXP_DA_ADES)
                              : pu_exp_da_e'(ex_pr_exp);
      w_nxt.badvaddr = w_dexp ? ex_pr_out : 32'h0;
    end else begin
      w_nxt.en      = 1'b1;
      w_nxt.pc      = ex_pr_pc;
      w_nxt.cop_op  = ex_pr_cop_op;
      w_nxt.rd_addr = ex_pr_rd_addr;
      w_nxt.rd_en   = ex_pr_rd_en;
      w_nxt.rd_data = w_ld ? w_ld_res : ex_pr_out;
      w_nxt.hi_en   = ex_pr_hi_en;
      w_nxt.hi_data = ex_pr_hi_data;
      w_nxt.lo_en   = ex_pr_lo_en;
      w_nxt.lo_data = ex_pr_lo_data;
      w_nxt.bd      = ex_pr_bd;
      w_nxt.exp     = PU_EXP_DA_NO;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_state <= DA_IDLE;
      r_op    <= PU_LS_OP_NO;
      r_baddr <= '0;
      r_sdata <= '0;
      r_done  <= 1'b0;
      r_buf   <= '0;
      r_pr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_idle && w_req) begin
        r_op    <= ex_pr_ls_op;
        r_baddr <= ex_pr_out;
        r_sdata <= ex_pr_st_data;
      end
      if (w_adv) begin
        r_pr   <= w_nxt;
        r_done <= 1'b0;
      end else if (w_cmpl) begin
        r_done <= 1'b1;
        r_buf  <= w_ld_data;
      end
      if (da_flush) r_done <= 1'b0;
    end
  end

  assign da_pr_en       = r_pr.en;
  assign da_pr_pc       = r_pr.pc;
  assign da_pr_cop_op   = r_pr.cop_op;
  assign da_pr_rd_addr  = r_pr.rd_addr;
  assign da_pr_rd_en    = r_pr.rd_en;
  assign da_pr_rd_data  = r_pr.rd_data;
  assign da_pr_hi_en    = r_pr.hi_en;
  assign da_pr_hi_data  = r_pr.hi_data;
  assign da_pr_lo_en    = r_pr.lo_en;
  assign da_pr_lo_data  = r_pr.lo_data;
  assign da_pr_bd       = r_pr.bd;
  assign da_pr_exp      = r_pr.exp;
  assign da_pr_badvaddr = r_pr.badvaddr;

  assign fwd_da_rd_addr = w_nxt.rd_addr;
  assign fwd_da_rd_en   = w_nxt.rd_en;
  assign fwd_da_rd_data = w_nxt.rd_data;

endmodule

// File: tb/tb_pu_da.sv
// Directed bench for pu_da: bus timing, lane handling, alignment faults, stall, flush, reset.
module tb_pu_da;
  import pu_da_pkg::*;

  logic        clk = 1'b0;
  logic        rst_, da_flush, da_stall, da_busy;
  logic        ex_pr_en, ex_pr_rd_en, ex_pr_hi_en, ex_pr_lo_en, ex_pr_bd;
  logic [29:0] ex_pr_pc;
  pu_cop_op_e  ex_pr_cop_op;
  pu_ls_op_e   ex_pr_ls_op;
  logic [31:0] ex_pr_out, ex_pr_st_data, ex_pr_hi_data, ex_pr_lo_data;
  logic [4:0]  ex_pr_rd_addr;
  pu_exp_ex_e  ex_pr_exp;
  logic        dbus_req, dbus_we, dbus_ack;
  logic [29:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata, dbus_rdata;
  logic        da_pr_en, da_pr_rd_en, da_pr_hi_en, da_pr_lo_en, da_pr_bd;
  logic [29:0] da_pr_pc;
  pu_cop_op_e  da_pr_cop_op;
  logic [4:0]  da_pr_rd_addr;
  logic [31:0] da_pr_rd_data, da_pr_hi_data, da_pr_lo_data, da_pr_badvaddr;
  pu_exp_da_e  da_pr_exp;
  logic [4:0]  fwd_da_rd_addr;
  logic        fwd_da_rd_en;
  logic [31:0] fwd_da_rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pu_da dut (
    .clk(clk), .rst_(rst_), .da_flush(da_flush), .da_stall(da_stall), .da_busy(da_busy),
    .ex_pr_en(ex_pr_en), .ex_pr_pc(ex_pr_pc), .ex_pr_cop_op(ex_pr_cop_op),
    .ex_pr_ls_op(ex_pr_ls_op), .ex_pr_out(ex_pr_out), .ex_pr_st_data(ex_pr_st_data),
    .ex_pr_rd_addr(ex_pr_rd_addr), .ex_pr_rd_en(ex_pr_rd_en), .ex_pr_hi_en(ex_pr_hi_en),
    .ex_pr_lo_en(ex_pr_lo_en), .ex_pr_hi_data(ex_pr_hi_data), .ex_pr_lo_data(ex_pr_lo_data),
    .ex_pr_bd(ex_pr_bd), .ex_pr_exp(ex_pr_exp),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .da_pr_en(da_pr_en), .da_pr_pc(da_pr_pc), .da_pr_cop_op(da_pr_cop_op),
    .da_pr_rd_addr(da_pr_rd_addr), .da_pr_rd_en(da_pr_rd_en), .da_pr_rd_data(da_pr_rd_data),
    .da_pr_hi_en(da_pr_hi_en), .da_pr_hi_data(da_pr_hi_data), .da_pr_lo_en(da_pr_lo_en),
    .da_pr_lo_data(da_pr_lo_data), .da_pr_bd(da_pr_bd), .da_pr_exp(da_pr_exp),
    .da_pr_badvaddr(da_pr_badvaddr),
    .fwd_da_rd_addr(fwd_da_rd_addr), .fwd_da_rd_en(fwd_da_rd_en), .fwd_da_rd_data(fwd_da_rd_data)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input pu_ls_op_e op, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic rde);
    ex_pr_en      = 1'b1;
    ex_pr_pc      = 30'h0000_1234;
    ex_pr_ls_op   = op;
    ex_pr_out     = addr;
    ex_pr_st_data = sdata;
    ex_pr_rd_addr = 5'd5;
    ex_pr_rd_en   = rde;
    ex_pr_exp     = PU_EXP_EX_NO;
  endtask

  typedef struct {
    pu_ls_op_e   op;
    logic [31:0] addr, sdata;
    logic        req, st, rde;
    logic [3:0]  be;
    logic [31:0] wdata, rd;
  } vec_t;

  vec_t vt[10];

  initial begin
    #100000;
    $display("FAIL watchdog act=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{PU_LS_OP_LB,  32'h103, 32'h0,        1'b1, 1'b0, 1'b1, 4'hF, 32'h0,        32'hFFFFFF80};
    vt[1] = '{PU_LS_OP_LBU, 32'h103, 32'h0,        1'b1, 1'b0, 1'b1, 4'hF, 32'h0,        32'h00000080};
    vt[2] = '{PU_LS_OP_LH,  32'h102, 32'h0,        1'b1, 1'b0, 1'b1, 4'hF, 32'h0,        32'hFFFF8011};
    vt[3] = '{PU_LS_OP_LHU, 32'h100, 32'h0,        1'b1, 1'b0, 1'b1, 4'hF, 32'h0,        32'h00002233};
    vt[4] = '{PU_LS_OP_LW,  32'h104, 32'h0,        1'b1, 1'b0, 1'b1, 4'hF, 32'h0,        32'h80112233};
    vt[5] = '{PU_LS_OP_LB,  32'h101, 32'h0,        1'b1, 1'b0, 1'b1, 4'hF, 32'h0,        32'h00000022};
    vt[6] = '{PU_LS_OP_SB,  32'h101, 32'h000055AB, 1'b1, 1'b1, 1'b0, 4'b0010, 32'hABABABAB, 32'h101};
    vt[7] = '{PU_LS_OP_SH,  32'h102, 32'hCAFE1234, 1'b1, 1'b1, 1'b0, 4'b1100, 32'h12341234, 32'h102};
    vt[8] = '{PU_LS_OP_SW,  32'h108, 32'h01020304, 1'b1, 1'b1, 1'b0, 4'hF, 32'h01020304, 32'h108};
    vt[9] = '{PU_LS_OP_NO,  32'h12345678, 32'h0,   1'b0, 1'b0, 1'b1, 4'h0, 32'h0,        32'h12345678};

    rst_ = 1'b0; da_flush = 1'b0; da_stall = 1'b0;
    ex_pr_cop_op = PU_COP_OP_NO; ex_pr_hi_en = 1'b0; ex_pr_lo_en = 1'b0; ex_pr_bd = 1'b0;
    ex_pr_hi_data = 32'h0; ex_pr_lo_data = 32'h0;
    drive(PU_LS_OP_LW, 32'h100, 32'h0, 1'b1);
    dbus_ack = 1'b0; dbus_rdata = 32'h0;
    cyc(); cyc();
    // reset state while a memory op is presented
    chk("rst_req", 32'(dbus_req), 32'd0);
    chk("rst_be", 32'(dbus_be), 32'd0);
    chk("rst_pr_en", 32'(da_pr_en), 32'd0);
    chk("rst_pr_exp", 32'(da_pr_exp), 32'(PU_EXP_DA_NO));
    chk("rst_pr_rd", da_pr_rd_data, 32'h0);
    ex_pr_en = 1'b0;
    rst_ = 1'b1;
    cyc();

    // SW 0x100 with ack two cycles late
    drive(PU_LS_OP_SW, 32'h100, 32'hDEADBEEF, 1'b0);
    #1;
    chk("sw_c0_req", 32'(dbus_req), 32'd1);
    chk("sw_c0_we", 32'(dbus_we), 32'd1);
    chk("sw_c0_addr", 32'(dbus_addr), 32'h40);
    chk("sw_c0_be", 32'(dbus_be), 32'hF);
    chk("sw_c0_wd", dbus_wdata, 32'hDEADBEEF);
    chk("sw_c0_busy", 32'(da_busy), 32'd1);
    cyc();
    ex_pr_st_data = 32'h0;
    #1;
    chk("sw_c1_req", 32'(dbus_req), 32'd1);
    chk("sw_c1_wd", dbus_wdata, 32'hDEADBEEF);
    chk("sw_c1_addr", 32'(dbus_addr), 32'h40);
    chk("sw_c1_busy", 32'(da_busy), 32'd1);
    chk("sw_c1_hold", 32'(da_pr_en), 32'd0);
    cyc();
    dbus_ack = 1'b1;
    #1;
    chk("sw_c2_req", 32'(dbus_req), 32'd1);
    chk("sw_c2_wd", dbus_wdata, 32'hDEADBEEF);
    chk("sw_c2_be", 32'(dbus_be), 32'hF);
    chk("sw_c2_busy", 32'(da_busy), 32'd0);
    cyc();
    chk("sw_pr_en", 32'(da_pr_en), 32'd1);
    chk("sw_pr_rden", 32'(da_pr_rd_en), 32'd0);
    chk("sw_pr_pc", 32'(da_pr_pc), 32'h1234);
    ex_pr_en = 1'b0; dbus_ack = 1'b0;
    #1;
    chk("sw_done_req", 32'(dbus_req), 32'd0);

    // zero-wait lane/extension vectors
    dbus_rdata = 32'h80112233;
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].op, vt[i].addr, vt[i].sdata, vt[i].rde);
      dbus_ack = vt[i].req;
      #1;
      chk($sformatf("v%0d_req", i), 32'(dbus_req), 32'(vt[i].req));
      chk($sformatf("v%0d_busy", i), 32'(da_busy), 32'd0);
      if (vt[i].req) begin
        chk($sformatf("v%0d_be", i), 32'(dbus_be), 32'(vt[i].be));
        chk($sformatf("v%0d_addr", i), 32'(dbus_addr), {2'b00, vt[i].addr[31:2]});
        chk($sformatf("v%0d_we", i), 32'(dbus_we), 32'(vt[i].st));
      end
      if (vt[i].st) chk($sformatf("v%0d_wd", i), dbus_wdata, vt[i].wdata);
      chk($sformatf("v%0d_fwd", i), fwd_da_rd_data, vt[i].rd);
      cyc();
      chk($sformatf("v%0d_rd", i), da_pr_rd_data, vt[i].rd);
      chk($sformatf("v%0d_rden", i), 32'(da_pr_rd_en), 32'(vt[i].rde));
    end

    // misaligned accesses raise DA exceptions without a bus request
    dbus_ack = 1'b0;
    drive(PU_LS_OP_LW, 32'h102, 32'h0, 1'b1);
    #1;
    chk("adel_req", 32'(dbus_req), 32'd0);
    cyc();
    chk("adel_exp", 32'(da_pr_exp), 32'(PU_EXP_DA_ADEL));
    chk("adel_bad", da_pr_badvaddr, 32'h102);
    chk("adel_rden", 32'(da_pr_rd_en), 32'd0);
    chk("adel_en", 32'(da_pr_en), 32'd1);
    drive(PU_LS_OP_SH, 32'h101, 32'h0, 1'b0);
    #1;
    chk("ades_req", 32'(dbus_req), 32'd0);
    cyc();
    chk("ades_exp", 32'(da_pr_exp), 32'(PU_EXP_DA_ADES));
    chk("ades_bad", da_pr_badvaddr, 32'h101);

    // incoming EX exception: carried, writes suppressed, no bus request for its load
    drive(PU_LS_OP_LW, 32'h200, 32'h0, 1'b1);
    ex_pr_exp = PU_EXP_EX_OVF; ex_pr_hi_en = 1'b1;
    #1;
    chk("exex_req", 32'(dbus_req), 32'd0);
    cyc();
    chk("exex_exp", 32'(da_pr_exp), 32'(PU_EXP_DA_OVF));
    chk("exex_rden", 32'(da_pr_rd_en), 32'd0);
    chk("exex_hien", 32'(da_pr_hi_en), 32'd0);
    chk("exex_en", 32'(da_pr_en), 32'd1);
    ex_pr_hi_en = 1'b0;

    // flush while waiting: drain until the late ack, then a bubble
    drive(PU_LS_OP_LW, 32'h200, 32'h0, 1'b1);
    cyc();
    da_flush = 1'b1;
    #1;
    chk("dr_busy0", 32'(da_busy), 32'd1);
    cyc();
    da_flush = 1'b0; ex_pr_en = 1'b0;
    #1;
    chk("dr_req1", 32'(dbus_req), 32'd1);
    chk("dr_addr1", 32'(dbus_addr), 32'h80);
    chk("dr_busy1", 32'(da_busy), 32'd1);
    chk("dr_hold1", 32'(da_pr_en), 32'd1);
    cyc();
    chk("dr_busy2", 32'(da_busy), 32'd1);
    cyc();
    dbus_ack = 1'b1;
    #1;
    chk("dr_busy3", 32'(da_busy), 32'd0);
    cyc();
    dbus_ack = 1'b0;
    #1;
    chk("dr_pr_en", 32'(da_pr_en), 32'd0);
    chk("dr_idle_req", 32'(dbus_req), 32'd0);

    // stall: completed load is buffered, not reissued, then delivered
    drive(PU_LS_OP_LW, 32'h300, 32'h0, 1'b1);
    da_stall = 1'b1; dbus_ack = 1'b1; dbus_rdata = 32'hAABBCCDD;
    #1;
    chk("st_req0", 32'(dbus_req), 32'd1);
    cyc();
    dbus_ack = 1'b0; dbus_rdata = 32'h0;
    #1;
    chk("st_noreq", 32'(dbus_req), 32'd0);
    chk("st_hold", da_pr_rd_data, 32'h0);
    da_stall = 1'b0;
    #1;
    chk("st_fwd", fwd_da_rd_data, 32'hAABBCCDD);
    cyc();
    chk("st_rd", da_pr_rd_data, 32'hAABBCCDD);

    // flush coincident with ack: result dropped, FSM back to IDLE
    drive(PU_LS_OP_LW, 32'h400, 32'h0, 1'b1);
    cyc();
    da_flush = 1'b1; dbus_ack = 1'b1;
    #1;
    chk("fa_busy", 32'(da_busy), 32'd0);
    cyc();
    da_flush = 1'b0; dbus_ack = 1'b0; ex_pr_en = 1'b0;
    #1;
    chk("fa_pr_en", 32'(da_pr_en), 32'd0);
    chk("fa_req", 32'(dbus_req), 32'd0);

    // reset during WAIT abandons the access
    drive(PU_LS_OP_NO, 32'h55, 32'h0, 1'b1);
    cyc();
    drive(PU_LS_OP_LW, 32'h500, 32'h0, 1'b1);
    cyc();
    #1;
    chk("rw_req", 32'(dbus_req), 32'd1);
    chk("rw_pr_en", 32'(da_pr_en), 32'd1);
    rst_ = 1'b0;
    cyc();
    chk("rw_rst_req", 32'(dbus_req), 32'd0);
    chk("rw_rst_pr", 32'(da_pr_en), 32'd0);
    chk("rw_rst_rd", da_pr_rd_data, 32'h0);
    rst_ = 1'b1; ex_pr_en = 1'b0;
    #1;
    chk("rw_idle_req", 32'(dbus_req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pu_da.md
PU_DA -- requirements
Module: pu_da

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; the ports are clk and rst_.
REQ-002 Port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-003 Port rst_, input, 1 bit: synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 Ports da_flush and da_stall, input, 1 bit each: pipeline kill and pipeline hold from the controller.
REQ-005 Port da_busy, output, 1 bit: a data access is outstanding, so upstream stages must stall.
REQ-006 EX/DA register inputs, all input:
- ex_pr_en, 1 bit
- ex_pr_pc, WordAddrBus (30 bits)
- ex_pr_cop_op, PuCopOpBus
- ex_pr_ls_op, PuLsOpBus
- ex_pr_out, 32 bits: byte address, or ALU result
- ex_pr_st_data, 32 bits
- ex_pr_rd_addr, 5 bits
- ex_pr_rd_en, 1 bit
- ex_pr_hi_en and ex_pr_lo_en, 1 bit each
- ex_pr_hi_data and ex_pr_lo_data, 32 bits each
- ex_pr_bd, 1 bit
- ex_pr_exp, PuExpExBus
REQ-007 Data-bus signals:
- dbus_req, output, 1 bit
- dbus_we, output, 1 bit
- dbus_addr, output, 30 bits: word address
- dbus_be, output, 4 bits: byte enables
- dbus_wdata, output, 32 bits
- dbus_ack, input, 1 bit
- dbus_rdata, input, 32 bits
REQ-008 DA/WB register outputs, all output:
- da_pr_en, da_pr_pc, da_pr_cop_op, da_pr_rd_addr, da_pr_rd_en
- da_pr_rd_data, 32 bits
- da_pr_hi_en, da_pr_hi_data, da_pr_lo_en, da_pr_lo_data, da_pr_bd
- da_pr_exp, PuExpDaBus
- da_pr_badvaddr, 32 bits
REQ-009 Forwarding outputs: fwd_da_rd_addr, fwd_da_rd_en and fwd_da_rd_data are combinational copies of the value that will be written into da_pr_*.

Function
REQ-010 A memory op exists when ex_pr_en=1, ex_pr_ls_op is not PU_LS_OP_NO, ex_pr_exp=PU_EXP_EX_NO and da_flush=0.
REQ-011 Misalignment rules:
- LH, LHU and SH require address bit 0 = 0.
- LW and SW require address bits [1:0] = 0.
- A misaligned load yields PU_EXP_DA_ADEL; a misaligned store yields PU_EXP_DA_ADES.
- da_pr_badvaddr = ex_pr_out; no bus request is issued.
REQ-012 Byte lanes are little-endian; offset 0 maps to bits [7:0].
- SB replicates byte[7:0] to all lanes, with be = one-hot of the offset.
- SH replicates halfword[15:0], with be = 0011 or 1100.
- SW uses be = 1111.
- Loads use be = 1111.
REQ-013 Load extraction:
- LB and LH sign-extend the selected lane.
- LBU and LHU zero-extend it.
- LW passes dbus_rdata through.
REQ-014 The FSM has three states: IDLE, WAIT and DRAIN.
- IDLE: on an aligned memory op, assert dbus_req. If dbus_ack arrives in the same cycle, complete; otherwise go to WAIT.
- WAIT: hold dbus_req, dbus_we, dbus_addr, dbus_be and dbus_wdata stable. On dbus_ack, complete and go to IDLE.
- WAIT with da_flush=1 goes to DRAIN. DRAIN holds the request until dbus_ack, then discards the result and goes to IDLE.
REQ-015 da_busy = (dbus_req & ~dbus_ack).
REQ-016 A zero-wait access gives 1-cycle latency into da_pr_*; each additional ack delay adds one cycle.
REQ-017 When da_stall=0 and da_busy=0, da_pr_* is updated:
- On flush or ex_pr_en=0: load the reset values.
- On an incoming or DA exception: en=1, pc and bd passed through, rd_en, hi_en and lo_en forced to 0, exp carried.
- Otherwise: pass through, with rd_data = load data for loads and ex_pr_out for all other ops.
REQ-018 When da_stall=1, da_pr_* holds; an access already in progress still completes on the bus and its load data is kept in an internal buffer.
REQ-019 A flush arriving in the same cycle as dbus_ack discards the result and returns the FSM to IDLE.

Reset
REQ-020 While rst_=0 at a rising edge:
- The FSM goes to IDLE.
- dbus_req, dbus_we and dbus_be are 0.
- All da_pr_* outputs are 0, with da_pr_exp = PU_EXP_DA_NO and da_pr_cop_op = PU_COP_OP_NO.
REQ-021 A reset during WAIT or DRAIN abandons the access; the bus tolerates dbus_req being dropped.

Structure
REQ-022 The PU_LS_OP_* codes, the PU_EXP_DA_* codes (NO, ADEL, ADES and the EX codes passed through) and the FSM state encodings live in pu.h.
REQ-023 Byte-enable generation, store replication and load extraction live in the combinational sub-module pu_da_align.

Verification
REQ-024 SW to address 0x100, data 0xDEADBEEF, ack arrives 2 cycles later:
- dbus_addr=0x40, be=1111, wdata held stable for 3 cycles.
- da_busy=1 for 2 cycles.
- da_pr_rd_en=0.
REQ-025 LB at address 0x103 with dbus_rdata=0x80112233 and a zero-wait ack -> da_pr_rd_data=0xFFFFFF80. LBU at the same address -> 0x00000080.
REQ-026 LW at address 0x102 -> no dbus_req, da_pr_exp=ADEL, da_pr_badvaddr=0x102, da_pr_rd_en=0.
REQ-027 LW waiting in WAIT, then da_flush pulses, then ack arrives 3 cycles later -> FSM goes to DRAIN and da_busy stays 1 until the ack; after that da_pr_en=0.
REQ-028 rst_=0 during WAIT -> at the next edge dbus_req=0, state=IDLE and all da_pr_* are 0.
